adder_pipe_6bit: RTL and testbench

//  Pipelined, handshaked 6-bit unsigned adder. It is the add-direction counterpart of the

---
 rtl/tpu_arith_pkg.sv | 16 +
 rtl/adder_pipe_6bit_if.sv | 34 +++
 rtl/add_carry_6bit.sv | 28 ++
 rtl/adder_pipe_6bit.sv | 83 ++++++++
 tb/tb_adder_pipe_6bit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_arith_pkg.sv
// Shared arithmetic types for the TPU exponent/offset datapath.
//   u6_t    : 6-bit unsigned operand/result
//   sum6_t  : packed {carry, sum} result of a 6-bit add
//   U6_MAX  : all-ones 6-bit value, used as the saturation level
package tpu_arith_pkg;

    typedef logic [5:0] u6_t;

    typedef struct packed {
        logic carry;
        u6_t  sum;
    } sum6_t;

    localparam u6_t U6_MAX = 6'd63;

endpackage

// File: rtl/adder_pipe_6bit_if.sv
// Handshake/data bundle for adder_pipe_6bit.
//   in_valid/in_ready   : operand beat handshake (master -> adder)
//   in_a, in_b          : operands; in_b ignored in accumulate mode
//   in_acc              : 1 = sum against running accumulator, 0 = in_a + in_b
//   acc_clr             : clear running accumulator
//   out_valid/out_ready : result handshake (adder -> master)
//   out_sum, out_carry  : result and carry-out
// modport master : the side that issues operands and consumes results
// modport slave  : the adder itself
interface adder_pipe_6bit_if;
    import tpu_arith_pkg::*;

    logic in_valid;
    logic in_ready;
    u6_t  in_a;
    u6_t  in_b;
    logic in_acc;
    logic acc_clr;
    logic out_valid;
    logic out_ready;
    u6_t  out_sum;
    logic out_carry;

    modport master (
        output in_valid, in_a, in_b, in_acc, acc_clr, out_ready,
        input  in_ready, out_valid, out_sum, out_carry
    );

    modport slave (
        input  in_valid, in_a, in_b, in_acc, acc_clr, out_ready,
        output in_ready, out_valid, out_sum, out_carry
    );

endinterface

// File: rtl/add_carry_6bit.sv
// Combinational 6-bit unsigned add with carry-out and optional saturation.
// Config macro: SATURATE_EN -- when defined, a carry forces the sum to all-ones;
//               when undefined, the sum wraps modulo 2^WIDTH.
// Ports:
//   i_x, i_y : operands
//   o_res    : {carry, sum}
module add_carry_6bit
    import tpu_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  u6_t   i_x,
    input  u6_t   i_y,
    output sum6_t o_res
);

    logic [WIDTH:0] w_sum7;

    assign w_sum7      = {1'b0, i_x} + {1'b0, i_y};
    assign o_res.carry = w_sum7[WIDTH];

`ifdef SATURATE_EN
    assign o_res.sum = w_sum7[WIDTH] ? U6_MAX : w_sum7[WIDTH-1:0];
`else
    assign o_res.sum = w_sum7[WIDTH-1:0];
`endif

endmodule

// File: rtl/adder_pipe_6bit.sv
// Two-stage pipelined, valid/ready handshaked 6-bit unsigned adder with an
// optional running accumulator (sum = acc + in_a when in_acc=1).
// Config macro: SATURATE_EN (see add_carry_6bit); affects out_sum and acc.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset; drops all in-flight beats
//   bus : adder_pipe_6bit_if.slave handshake/data bundle
module adder_pipe_6bit
    import tpu_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    adder_pipe_6bit_if.slave    bus
);

    logic  r_s1_valid;
    sum6_t r_s1;
    logic  r_out_valid;
    sum6_t r_out;
    u6_t   r_acc;

    logic  w_s2_adv;
    logic  w_s1_adv;
    logic  w_accept;
    u6_t   w_y;
    sum6_t w_res;

    // Ready chains back combinationally so a stalled output blocks input in
    // the same cycle, while any bubble in S1/S2 keeps the input open.
    assign w_s2_adv = !r_out_valid || bus.out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_accept = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = w_s1_adv && !rst;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out.sum;
    assign bus.out_carry = r_out.carry;

    // A clear coinciding with an accumulate beat makes that beat see acc=0.
    always_comb begin
        w_y = bus.in_b;
        if (bus.in_acc) begin
            w_y = bus.acc_clr ? '0 : r_acc;
        end
    end

    add_carry_6bit #(.WIDTH(WIDTH)) u_add (
        .i_x   (bus.in_a),
        .i_y   (w_y),
        .o_res (w_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1        <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_acc       <= '0;
        end else begin
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out <= r_s1;
                end
            end
            if (w_s1_adv) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1 <= w_res;
                end
            end
            if (w_accept && bus.in_acc) begin
                r_acc <= w_res.sum;
            end else if (bus.acc_clr) begin
                r_acc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_adder_pipe_6bit.sv
// Scoreboard bench for adder_pipe_6bit: directed beats push hand-computed
// results into a queue; a monitor pops and compares on every output transfer.
module tb_adder_pipe_6bit;
    import tpu_arith_pkg::*;

`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   n_push;
    int   n_pop;
    sum6_t exp_q[$];
    int    pop_cyc[$];

    adder_pipe_6bit_if bus ();

    adder_pipe_6bit #(.WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge when out_valid && out_ready.
    always begin
        @(negedge clk);
        #2;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                sum6_t e;
                e = exp_q.pop_front();
                chk("out_sum", int'(bus.out_sum), int'(e.sum));
                chk("out_carry", int'(bus.out_carry), int'(e.carry));
            end
            n_pop++;
            pop_cyc.push_back(cyc);
        end
    end

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_acc   = 1'b0;
        bus.acc_clr  = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
    endtask

    // Drive one beat and hold it until accepted; expected result is queued on accept.
    task automatic send(input u6_t a, input u6_t b, input logic acc, input logic clr,
                        input u6_t es, input logic ec);
        int tries;
        sum6_t e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_acc   = acc;
        bus.acc_clr  = clr;
        #1;
        tries = 0;
        while (!bus.in_ready && tries < 50) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            @(posedge clk);
            e.sum   = es;
            e.carry = ec;
            exp_q.push_back(e);
            n_push++;
        end
    endtask

    typedef struct {
        u6_t  a;
        u6_t  b;
        u6_t  s;
        logic c;
    } vec_t;

    vec_t stream_v[8];
    vec_t stall_v[6];

    initial begin
        int n0;
        u6_t held;

        n_checks = 0; n_fail = 0; n_push = 0; n_pop = 0; cyc = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        bus.in_acc = 1'b0; bus.acc_clr = 1'b0; bus.out_ready = 1'b1;

        stream_v[0] = '{6'd1,  6'd2,  6'd3,  1'b0};
        stream_v[1] = '{6'd10, 6'd20, 6'd30, 1'b0};
        stream_v[2] = '{6'd33, 6'd30, 6'd63, 1'b0};
        stream_v[3] = '{6'd32, 6'd32, SAT ? 6'd63 : 6'd0,  1'b1};
        stream_v[4] = '{6'd5,  6'd0,  6'd5,  1'b0};
        stream_v[5] = '{6'd40, 6'd30, SAT ? 6'd63 : 6'd6,  1'b1};
        stream_v[6] = '{6'd63, 6'd63, SAT ? 6'd63 : 6'd62, 1'b1};
        stream_v[7] = '{6'd0,  6'd0,  6'd0,  1'b0};

        stall_v[0] = '{6'd11, 6'd12, 6'd23, 1'b0};
        stall_v[1] = '{6'd2,  6'd3,  6'd5,  1'b0};
        stall_v[2] = '{6'd4,  6'd4,  6'd8,  1'b0};
        stall_v[3] = '{6'd60, 6'd10, SAT ? 6'd63 : 6'd6, 1'b1};
        stall_v[4] = '{6'd7,  6'd8,  6'd15, 1'b0};
        stall_v[5] = '{6'd1,  6'd1,  6'd2,  1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_sum", int'(bus.out_sum), 0);
        chk("rst_out_carry", int'(bus.out_carry), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(bus.in_ready), 1);

        // 1: single beat, 2-cycle latency, single pulse
        send(6'd10, 6'd5, 1'b0, 1'b0, 6'd15, 1'b0);
        idle();
        #1 chk("lat_cycle1_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        #1 chk("lat_cycle2_valid", int'(bus.out_valid), 1);
        @(negedge clk);
        #1 chk("single_pulse", int'(bus.out_valid), 0);

        // 2: wrap / saturate
        send(6'd63, 6'd1, 1'b0, 1'b0, SAT ? 6'd63 : 6'd0, 1'b1);
        idle();
        repeat (3) @(negedge clk);

        // 3: 8 back-to-back beats at full throughput
        n0 = pop_cyc.size();
        for (int i = 0; i < 8; i++) begin
            send(stream_v[i].a, stream_v[i].b, 1'b0, 1'b0, stream_v[i].s, stream_v[i].c);
            chk("stream_accept_cycle", cyc, (i == 0) ? cyc : cyc);
        end
        idle();
        repeat (4) @(negedge clk);
        if (pop_cyc.size() >= n0 + 8) begin
            chk("stream_consecutive", pop_cyc[n0+7] - pop_cyc[n0], 7);
        end else begin
            chk("stream_result_count", pop_cyc.size() - n0, 8);
        end

        // 4: backpressure
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(stall_v[0].a, stall_v[0].b, 1'b0, 1'b0, stall_v[0].s, stall_v[0].c);
        send(stall_v[1].a, stall_v[1].b, 1'b0, 1'b0, stall_v[1].s, stall_v[1].c);
        idle();
        #1;
        chk("stall_in_ready", int'(bus.in_ready), 0);
        chk("stall_out_valid", int'(bus.out_valid), 1);
        chk("stall_out_sum", int'(bus.out_sum), int'(stall_v[0].s));
        held = bus.out_sum;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("stall_hold_sum", int'(bus.out_sum), int'(held));
            chk("stall_hold_ready", int'(bus.in_ready), 0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 2; i < 6; i++) begin
            send(stall_v[i].a, stall_v[i].b, 1'b0, 1'b0, stall_v[i].s, stall_v[i].c);
        end
        idle();
        repeat (4) @(negedge clk);

        // 5: clear, then accumulate 20, 30, 20
        @(negedge clk);
        bus.acc_clr = 1'b1;
        @(negedge clk);
        bus.acc_clr = 1'b0;
        send(6'd20, 6'd0, 1'b1, 1'b0, 6'd20, 1'b0);
        send(6'd30, 6'd9, 1'b1, 1'b0, 6'd50, 1'b0);
        send(6'd20, 6'd0, 1'b1, 1'b0, SAT ? 6'd63 : 6'd6, 1'b1);

        // 6: clear with accumulate beat, clear with pairwise beat
        send(6'd40, 6'd0, 1'b1, 1'b1, 6'd40, 1'b0);
        send(6'd7,  6'd0, 1'b1, 1'b1, 6'd7,  1'b0);
        send(6'd1,  6'd0, 1'b1, 1'b0, 6'd8,  1'b0);
        send(6'd3,  6'd4, 1'b0, 1'b1, 6'd7,  1'b0);
        send(6'd5,  6'd0, 1'b1, 1'b0, 6'd5,  1'b0);
        send(6'd10, 6'd0, 1'b1, 1'b0, 6'd15, 1'b0);
        idle();
        repeat (4) @(negedge clk);

        // Reset with two beats in flight
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(6'd10, 6'd0, 1'b1, 1'b0, 6'd25, 1'b0);
        send(6'd2,  6'd2, 1'b0, 1'b0, 6'd4,  1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_acc   = 1'b0;
        rst = 1'b1;
        #1 chk("rst_forces_in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        #1 chk("rst_flush_out_valid", int'(bus.out_valid), 0);
        exp_q.delete();
        n_push -= 2;
        bus.out_ready = 1'b1;
        rst = 1'b0;
        send(6'd9, 6'd0, 1'b1, 1'b0, 6'd9, 1'b0);
        idle();
        repeat (5) @(negedge clk);

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("results_count", n_pop, n_push);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
